screen_guard_ctrl: RTL and testbench

//  Frame-synchronous screen-off controller for the child-protection TV path.
//  - Watches a proximity-detect input and blanks the VGA RGB stream when a

---
 rtl/screen_guard_ctrl.sv | 147 ++++++++++++++
 tb/tb_screen_guard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/screen_guard_ctrl.sv
// Frame-synchronous screen-off guard: blanks the RGB stream while a viewer stays too close.
// Optional red warning flash while ARMED is built only when GUARD_WARN_EN is defined.
module screen_guard_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int ARM_FRAMES   = 30,
  parameter int CLEAR_FRAMES = 120,
  parameter int CNT_W        = 8
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        near_det,
  input  logic        p_tick,
  input  logic        frame_tick,
  input  logic        video_on,
  input  logic [11:0] rgb_in,
  output logic [11:0] rgb_out,
  output logic        blank_active,
  output logic [1:0]  state,
  output logic [7:0]  blank_events
);

  typedef enum logic [1:0] {
    WATCH = 2'd0,
    ARMED = 2'd1,
    BLANK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ARM_LIM   = CNT_W'(ARM_FRAMES);
  localparam logic [CNT_W-1:0] CLEAR_LIM = CNT_W'(CLEAR_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_next;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic                     w_event;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     w_near_s;
  logic                     r_blank;
  logic [7:0]               r_events;
  logic [11:0]              r_rgb;
  logic [11:0]              w_pix;

  assign w_near_s  = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '0;
      r_state  <= WATCH;
      r_cnt    <= '0;
      r_blank  <= 1'b0;
      r_events <= 8'd0;
      r_rgb    <= 12'h000;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], near_det};
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Registered off the next state so blank_active and state change together.
      r_blank <= (w_state_next == BLANK) || (w_state_next == HOLD);
      if (w_event && (r_events != 8'hFF)) begin
        r_events <= r_events + 8'd1;
      end
      if (p_tick) begin
        r_rgb <= (!video_on || r_blank) ? 12'h000 : w_pix;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_event      = 1'b0;
    if (!enable) begin
      w_state_next = WATCH;
      w_cnt_next   = '0;
    end else if (frame_tick) begin
      unique case (r_state)
        WATCH: begin
          if (w_near_s) begin
            if (ARM_LIM == CNT_ONE) begin
              w_state_next = BLANK;
              w_cnt_next   = '0;
              w_event      = 1'b1;
            end else begin
              w_state_next = ARMED;
              w_cnt_next   = CNT_ONE;
            end
          end
        end
        ARMED: begin
          if (!w_near_s) begin
            w_state_next = WATCH;
            w_cnt_next   = '0;
          end else if (w_cnt_inc == ARM_LIM) begin
            w_state_next = BLANK;
            w_cnt_next   = '0;
            w_event      = 1'b1;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        BLANK: begin
          if (!w_near_s) begin
            if (CLEAR_LIM == CNT_ONE) begin
              w_state_next = WATCH;
              w_cnt_next   = '0;
            end else begin
              w_state_next = HOLD;
              w_cnt_next   = CNT_ONE;
            end
          end
        end
        HOLD: begin
          if (w_near_s) begin
            w_state_next = BLANK;
            w_cnt_next   = '0;
          end else if (w_cnt_inc == CLEAR_LIM) begin
            w_state_next = WATCH;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        default: begin
          w_state_next = WATCH;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef GUARD_WARN_EN
  assign w_pix = ((r_state == ARMED) && r_cnt[2]) ? (rgb_in | 12'hF00) : rgb_in;
`else
  assign w_pix = rgb_in;
`endif

  assign rgb_out      = r_rgb;
  assign blank_active = r_blank;
  assign state        = r_state;
  assign blank_events = r_events;

endmodule

// File: tb/tb_screen_guard_ctrl.sv
// Randomized bench for screen_guard_ctrl against a run-length model of the guard rules.
// Near_det only changes well clear of frame_tick, so the model can read it directly.
module tb_screen_guard_ctrl;
  localparam int ARM    = 3;
  localparam int CLR    = 4;
  localparam int FLEN   = 12;
  localparam int FT_POS = 10;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        near_det = 1'b0;
  logic        p_tick = 1'b0;
  logic        frame_tick = 1'b0;
  logic        video_on = 1'b1;
  logic [11:0] rgb_in = 12'hABC;
  logic [11:0] rgb_out;
  logic        blank_active;
  logic [1:0]  state;
  logic [7:0]  blank_events;

  screen_guard_ctrl #(
    .SYNC_STAGES (2),
    .ARM_FRAMES  (ARM),
    .CLEAR_FRAMES(CLR),
    .CNT_W       (8)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .enable      (enable),
    .near_det    (near_det),
    .p_tick      (p_tick),
    .frame_tick  (frame_tick),
    .video_on    (video_on),
    .rgb_in      (rgb_in),
    .rgb_out     (rgb_out),
    .blank_active(blank_active),
    .state       (state),
    .blank_events(blank_events)
  );

  always #5 clk_50 = ~clk_50;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_no = 0;
  bit rnd_pix = 1'b0;

  // Guard model: a viewer is either blanked or not, plus the length of the current near/clear run.
  bit          m_blanked;
  int          m_near_run;
  int          m_clear_run;
  int          m_events;
  logic [11:0] m_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (frame %0d, t=%0t)", tag, got, exp, frame_no, $time);
    end
  endtask

  function automatic int m_state();
    if (!m_blanked) return (m_near_run > 0) ? 1 : 0;
    return (m_clear_run > 0) ? 3 : 2;
  endfunction

  task automatic model_reset();
    m_blanked   = 1'b0;
    m_near_run  = 0;
    m_clear_run = 0;
    m_events    = 0;
    m_rgb       = 12'h000;
  endtask

  task automatic model_edge();
    logic [11:0] pix;
    if (p_tick) begin
      pix = rgb_in;
`ifdef GUARD_WARN_EN
      if (!m_blanked && (m_near_run > 0) && ((m_near_run & 4) != 0)) pix = pix | 12'hF00;
`endif
      m_rgb = (!video_on || m_blanked) ? 12'h000 : pix;
    end
    if (!enable) begin
      m_blanked   = 1'b0;
      m_near_run  = 0;
      m_clear_run = 0;
    end else if (frame_tick) begin
      if (!m_blanked) begin
        if (near_det) begin
          m_near_run++;
          if (m_near_run == ARM) begin
            m_blanked  = 1'b1;
            m_near_run = 0;
            if (m_events < 255) m_events++;
          end
        end else begin
          m_near_run = 0;
        end
      end else begin
        if (!near_det) begin
          m_clear_run++;
          if (m_clear_run == CLR) begin
            m_blanked   = 1'b0;
            m_clear_run = 0;
          end
        end else begin
          m_clear_run = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state), 32'(m_state()));
    check({tag, ".blank"}, 32'(blank_active), 32'(m_blanked));
    check({tag, ".rgb"}, 32'(rgb_out), 32'(m_rgb));
    check({tag, ".events"}, 32'(blank_events), 32'(m_events));
  endtask

  task automatic cycle(input bit ft, input bit en, input bit nd, input bit rst);
    @(negedge clk_50);
    frame_tick = ft;
    enable     = en;
    near_det   = nd;
    p_tick     = 1'($urandom_range(0, 1));
    if (rnd_pix) begin
      rgb_in   = 12'($urandom);
      video_on = ($urandom_range(0, 7) != 0);
    end else begin
      rgb_in   = 12'hABC;
      video_on = 1'b1;
    end
    if (rst) begin
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_all("async_rst");
      #1 reset_n = 1'b1;
    end
    @(posedge clk_50);
    #1;
    model_edge();
    check_all("cyc");
  endtask

  task automatic frame(input bit nd, input bit glitch, input bit en_mid, input bit en_tick,
                       input bit rst_mid);
    for (int c = 0; c < FLEN; c++) begin
      cycle(c == FT_POS,
            !((en_mid && c == 6) || (en_tick && c == FT_POS)),
            (glitch && c == 4) ? !nd : nd,
            rst_mid && c == 5);
    end
    $display("[TB] frame %0d near=%0d gl=%0d en_mid=%0d en_ft=%0d rst=%0d -> state=%0d blank=%0d events=%0d rgb=%03h",
             frame_no, nd, glitch, en_mid, en_tick, rst_mid, state, blank_active, blank_events, rgb_out);
    frame_no++;
  endtask

  initial begin
    bit nd;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk_50);
    @(negedge clk_50);
    reset_n = 1'b1;
    enable  = 1'b1;

    for (int i = 0; i < 5; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    rnd_pix = 1'b1;
    nd = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 3) nd = !nd;
      frame(nd,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
